// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: opcodes, funct codes, ALU ops, FSM states.
package exec_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_HALT   = 7'b1111111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] F7_MDU    = 7'b0000001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/exec_unit_mdu_mdu_iter.sv
// Iterative RV32M multiply/divide core: radix-2 shift-add multiply and restoring
// divide on magnitudes, sharing one XLEN+1 adder. One bit per cycle for XLEN cycles;
// 'last' flags the final iteration, 'result' is sign-corrected and valid afterwards.
module mdu_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  // Two's-complement magnitude of v when n is set.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic n);
    if (n) mag = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    else   mag = v;
  endfunction

  logic             active_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  logic [XLEN-1:0]  hi_r;    // product high half / partial remainder
  logic [XLEN-1:0]  lo_r;    // multiplier / quotient being built
  logic [XLEN-1:0]  dsr_r;   // multiplicand or divisor magnitude
  logic             neg_r;   // final result needs negation
  logic             dz_r;    // divisor was zero

  logic             sgn_a_s, sgn_b_s, sa_s, sb_s, is_div_s;
  logic [XLEN:0]    add_x_s, add_y_s, acc_s;
  logic [XLEN+1:0]  sum_s;
  logic [XLEN-1:0]  hi_n_s, lo_n_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  assign sgn_a_s = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  assign sgn_b_s = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  assign sa_s    = sgn_a_s & a[XLEN-1];
  assign sb_s    = sgn_b_s & b[XLEN-1];
  assign is_div_s = op_r[2];
  assign last    = active_r && (cnt_r == CNT_LAST);

  // Shared adder: add multiplicand for multiply, trial-subtract divisor for divide.
  always_comb begin
    if (is_div_s) begin
      add_x_s = {hi_r, lo_r[XLEN-1]};
      add_y_s = ~{1'b0, dsr_r};
    end else begin
      add_x_s = {1'b0, hi_r};
      add_y_s = {1'b0, dsr_r};
    end
    sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{(XLEN+1){1'b0}}, is_div_s};
  end

  // One iteration step of either algorithm.
  always_comb begin
    acc_s = {1'b0, hi_r};
    if (is_div_s) begin
      if (sum_s[XLEN+1]) begin
        hi_n_s = sum_s[XLEN-1:0];
        lo_n_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_n_s = add_x_s[XLEN-1:0];
        lo_n_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo_r[0]) acc_s = sum_s[XLEN:0];
      else         acc_s = {1'b0, hi_r};
      hi_n_s = acc_s[XLEN:1];
      lo_n_s = {acc_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Operand latch on start, then one step per cycle until the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
      op_r     <= 3'b000;
      hi_r     <= '0;
      lo_r     <= '0;
      dsr_r    <= '0;
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
    end else if (kill) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
      op_r     <= op;
      hi_r     <= '0;
      lo_r     <= mag(a, sa_s);
      dsr_r    <= mag(b, sb_s);
      neg_r    <= (op == MDU_REM) ? sa_s : (sa_s ^ sb_s);
      dz_r     <= (b == '0);
    end else if (active_r) begin
      hi_r  <= hi_n_s;
      lo_r  <= lo_n_s;
      cnt_r <= cnt_r + CNT_ONE;
      if (last) active_r <= 1'b0;
    end
  end

  // Sign correction and result selection; divide-by-zero quotient forced to all ones.
  always_comb begin
    prod_s = {hi_r, lo_r};
    if (neg_r) prod_fix_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
    else       prod_fix_s = prod_s;
    case (op_r)
      MDU_MUL:                          result = prod_fix_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  result = prod_fix_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                result = dz_r ? {XLEN{1'b1}} : mag(lo_r, neg_r);
      MDU_REM, MDU_REMU:                result = mag(hi_r, neg_r);
      default:                          result = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit_mdu.sv
// Execute stage: inline ALU and branch/jump resolver plus iterative MDU behind a
// valid/ready handshake. All outputs come from registers; one result per accepted op.
module exec_unit_mdu
  import exec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [3:0]      alu_op,
  input  logic            alu_src1,
  input  logic            alu_src2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            reg_wr,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            flush_req,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_e          state_r, state_n;
  logic            out_valid_r, reg_wr_r, redirect_r, flush_req_r;
  logic [XLEN-1:0] result_r, target_r;
  logic            ov_n, rw_n, rd_n;
  logic [XLEN-1:0] res_n, tg_n;

  logic [XLEN-1:0] op_a_s, op_b_s, alu_res_s, pc_imm_s, jalr_sum_s, link_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic            is_mdu_op_s, is_mdu_s, taken_s;
  alu_op_e         alu_eff_s;
  logic [XLEN-1:0] exe_res_s, exe_tgt_s;
  logic            exe_rw_s, exe_redir_s;
  logic            mdu_start_s, mdu_last_s;
  logic [XLEN-1:0] mdu_res_s;

  assign op_a_s      = alu_src1 ? pc : rs1_data;
  assign op_b_s      = alu_src2 ? imm : rs2_data;
  assign shamt_s     = op_b_s[SHAMT_W-1:0];
  assign is_mdu_op_s = (opcode == OP_OP) && (funct7 == F7_MDU);
  assign is_mdu_s    = MDU_EN && is_mdu_op_s;
  // MDU encodings fall back to ADD when the MDU is configured out.
  assign alu_eff_s   = is_mdu_op_s ? ALU_ADD : alu_op_e'(alu_op);
  assign pc_imm_s    = pc + imm;
  assign jalr_sum_s  = rs1_data + imm;
  assign link_s      = pc + XLEN'(3'd4);

  assign in_ready  = (state_r == IDLE) && !flush;
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign reg_wr    = reg_wr_r;
  assign redirect  = redirect_r;
  assign target    = target_r;
  assign flush_req = flush_req_r;

  // Integer ALU.
  always_comb begin
    alu_res_s = op_a_s + op_b_s;
    case (alu_eff_s)
      ALU_ADD:  alu_res_s = op_a_s + op_b_s;
      ALU_SUB:  alu_res_s = op_a_s - op_b_s;
      ALU_XOR:  alu_res_s = op_a_s ^ op_b_s;
      ALU_OR:   alu_res_s = op_a_s | op_b_s;
      ALU_AND:  alu_res_s = op_a_s & op_b_s;
      ALU_SLL:  alu_res_s = op_a_s << shamt_s;
      ALU_SRL:  alu_res_s = op_a_s >> shamt_s;
      ALU_SRA:  alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      default:  alu_res_s = op_a_s + op_b_s;
    endcase
  end

  // Branch condition on rs1/rs2; funct3 010/011 never take.
  always_comb begin
    taken_s = 1'b0;
    case (funct3)
      F3_BEQ:  taken_s = (rs1_data == rs2_data);
      F3_BNE:  taken_s = (rs1_data != rs2_data);
      F3_BLT:  taken_s = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  taken_s = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken_s = (rs1_data <  rs2_data);
      F3_BGEU: taken_s = (rs1_data >= rs2_data);
      default: taken_s = 1'b0;
    endcase
  end

  // Single-cycle result, write-enable and redirect for non-MDU ops.
  always_comb begin
    exe_res_s   = alu_res_s;
    exe_tgt_s   = pc_imm_s;
    exe_rw_s    = 1'b1;
    exe_redir_s = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        exe_rw_s    = 1'b0;
        exe_redir_s = taken_s;
      end
      OP_JAL: begin
        exe_res_s   = link_s;
        exe_redir_s = 1'b1;
      end
      OP_JALR: begin
        exe_res_s   = link_s;
        exe_tgt_s   = {jalr_sum_s[XLEN-1:1], 1'b0};
        exe_redir_s = 1'b1;
      end
      OP_STORE, OP_HALT: exe_rw_s = 1'b0;
      default: exe_rw_s = 1'b1;
    endcase
  end

  // FSM next state and next registered outputs; flush kills whatever is in flight.
  always_comb begin
    state_n     = state_r;
    ov_n        = 1'b0;
    rw_n        = 1'b0;
    rd_n        = 1'b0;
    res_n       = result_r;
    tg_n        = target_r;
    mdu_start_s = 1'b0;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (is_mdu_s) begin
              mdu_start_s = 1'b1;
              state_n     = ITER;
            end else begin
              ov_n  = 1'b1;
              res_n = exe_res_s;
              tg_n  = exe_tgt_s;
              rw_n  = exe_rw_s;
              rd_n  = exe_redir_s;
            end
          end else begin
            state_n = IDLE;
          end
        end
        ITER: begin
          if (mdu_last_s) state_n = FIN;
          else            state_n = ITER;
        end
        FIN: begin
          ov_n    = 1'b1;
          res_n   = mdu_res_s;
          rw_n    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      reg_wr_r    <= 1'b0;
      redirect_r  <= 1'b0;
      flush_req_r <= 1'b0;
      result_r    <= '0;
      target_r    <= '0;
    end else begin
      state_r     <= state_n;
      out_valid_r <= ov_n;
      reg_wr_r    <= rw_n;
      redirect_r  <= rd_n;
      flush_req_r <= rd_n;
      result_r    <= res_n;
      target_r    <= tg_n;
    end
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .kill   (flush),
    .start  (mdu_start_s),
    .op     (funct3),
    .a      (op_a_s),
    .b      (op_b_s),
    .last   (mdu_last_s),
    .result (mdu_res_s)
  );

endmodule

// File: tb/tb_exec_unit_mdu.sv
// Directed bench for exec_unit_mdu with hand-computed expectations.
module tb_exec_unit_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0;
  logic [6:0]  opcode = 7'd0, funct7 = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [3:0]  alu_op = 4'd0;
  logic        alu_src1 = 1'b0, alu_src2 = 1'b0;
  logic [31:0] rs1_data = 32'd0, rs2_data = 32'd0, imm = 32'd0, pc = 32'd0;
  logic        in_ready, out_valid, reg_wr, redirect, flush_req, busy;
  logic [31:0] result, target;

  int vectors = 0;
  int miscompares = 0;
  logic seen_ov;

  exec_unit_mdu #(.XLEN(32), .MDU_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .alu_op(alu_op),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .out_valid(out_valid), .result(result), .reg_wr(reg_wr),
    .redirect(redirect), .target(target), .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] aop, input logic s1, input logic s2,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    in_valid = 1'b1; opcode = opc; funct3 = f3; funct7 = f7; alu_op = aop;
    alu_src1 = s1; alu_src2 = s2; rs1_data = r1; rs2_data = r2; imm = im; pc = p;
  endtask

  // Issue an MDU op and step to the cycle where its out_valid should show (accept+33).
  task automatic mdu_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    issue(7'b0110011, f3, 7'b0000001, 4'd0, 1'b0, 1'b0, a, b, 32'd0, 32'd0);
    tick;
    in_valid = 1'b0;
    repeat (32) tick;
    checkb("mdu_not_early", out_valid, 1'b0);
    tick;
  endtask

  initial begin
    // Reset values
    #1;
    checkb("rst_in_ready", in_ready, 1'b1);
    checkb("rst_out_valid", out_valid, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_target", target, 32'h0);
    tick; tick;
    rst = 1'b0;

    // ADD with immediate, then back-to-back ALU ops one per cycle
    issue(7'b0010011, 3'd0, 7'd0, 4'd0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0);
    tick;
    checkb("add_ov", out_valid, 1'b1);
    check("add_res", result, 32'h8000_0000);
    checkb("add_rw", reg_wr, 1'b1);
    checkb("add_redir", redirect, 1'b0);
    issue(7'b0110011, 3'd0, 7'd0, 4'd7, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    tick;
    checkb("sra_ov", out_valid, 1'b1);
    check("sra_res", result, 32'hF800_0000);
    issue(7'b0110011, 3'd0, 7'd0, 4'd6, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    tick;
    check("srl_res", result, 32'h0800_0000);
    issue(7'b0110011, 3'd0, 7'd0, 4'd5, 1'b0, 1'b0, 32'h3, 32'h21, 32'd0, 32'd0);
    tick;
    check("sll_shamt_res", result, 32'h6);
    issue(7'b0110011, 3'd0, 7'd0, 4'd8, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    tick;
    check("slt_res", result, 32'h1);
    issue(7'b0110011, 3'd0, 7'd0, 4'd9, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    tick;
    check("sltu_res", result, 32'h0);
    issue(7'b0110011, 3'd0, 7'd0, 4'd1, 1'b1, 1'b0, 32'd0, 32'h10, 32'd0, 32'h100);
    tick;
    check("sub_pc_res", result, 32'hF0);
    in_valid = 1'b0;
    tick;
    checkb("pulse_one_cycle", out_valid, 1'b0);

    // Branches
    issue(7'b1100011, 3'b110, 7'd0, 4'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000);
    tick;
    checkb("bltu_ov", out_valid, 1'b1);
    checkb("bltu_redir", redirect, 1'b0);
    checkb("bltu_rw", reg_wr, 1'b0);
    issue(7'b1100011, 3'b100, 7'd0, 4'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h1000);
    tick;
    checkb("blt_redir", redirect, 1'b1);
    checkb("blt_flush_req", flush_req, 1'b1);
    check("blt_target", target, 32'h1020);
    checkb("blt_rw", reg_wr, 1'b0);
    issue(7'b1100011, 3'b101, 7'd0, 4'd0, 1'b0, 1'b0, 32'd5, 32'd5, 32'h40, 32'h2000);
    tick;
    checkb("bge_eq_redir", redirect, 1'b1);
    check("bge_target", target, 32'h2040);
    issue(7'b1100011, 3'b111, 7'd0, 4'd0, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h2000);
    tick;
    checkb("bgeu_lt_redir", redirect, 1'b0);
    issue(7'b1100011, 3'b010, 7'd0, 4'd0, 1'b0, 1'b0, 32'd5, 32'd5, 32'h40, 32'h2000);
    tick;
    checkb("br_f3_010_redir", redirect, 1'b0);
    checkb("br_f3_010_rw", reg_wr, 1'b0);
    in_valid = 1'b0;
    tick;
    checkb("redir_qualified", redirect, 1'b0);
    checkb("flush_req_qualified", flush_req, 1'b0);

    // Jumps and store
    issue(7'b1100111, 3'd0, 7'd0, 4'd0, 1'b0, 1'b1, 32'h203, 32'd0, 32'd0, 32'h100);
    tick;
    check("jalr_target", target, 32'h202);
    check("jalr_result", result, 32'h104);
    checkb("jalr_redir", redirect, 1'b1);
    checkb("jalr_rw", reg_wr, 1'b1);
    issue(7'b1101111, 3'd0, 7'd0, 4'd0, 1'b1, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h200);
    tick;
    check("jal_target", target, 32'h1F8);
    check("jal_result", result, 32'h204);
    checkb("jal_flush_req", flush_req, 1'b1);
    issue(7'b0100011, 3'b010, 7'd0, 4'd0, 1'b0, 1'b1, 32'h300, 32'h5, 32'h10, 32'h300);
    tick;
    checkb("store_ov", out_valid, 1'b1);
    checkb("store_rw", reg_wr, 1'b0);
    checkb("store_redir", redirect, 1'b0);
    in_valid = 1'b0;
    tick;

    // MULH with full busy/in_ready profile
    issue(7'b0110011, 3'b001, 7'b0000001, 4'd0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin
      check("mulh_busy_profile", {29'd0, busy, in_ready, out_valid}, {29'd0, 3'b100});
      tick;
    end
    checkb("mulh_ov", out_valid, 1'b1);
    check("mulh_res", result, 32'h4000_0000);
    checkb("mulh_rw", reg_wr, 1'b1);
    checkb("mulh_busy_done", busy, 1'b0);
    tick;
    checkb("mulh_pulse", out_valid, 1'b0);

    // More MDU results
    mdu_run(3'b000, 32'hFFFF_FFFF, 32'd3);
    check("mul_res", result, 32'hFFFF_FFFD);
    mdu_run(3'b010, 32'hFFFF_FFFF, 32'd3);
    check("mulhsu_res", result, 32'hFFFF_FFFF);
    mdu_run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_res", result, 32'hFFFF_FFFE);
    mdu_run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_res", result, 32'h8000_0000);
    mdu_run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    check("rem_ovf_res", result, 32'h0);
    mdu_run(3'b111, 32'd7, 32'd0);
    check("remu_dz_res", result, 32'd7);
    mdu_run(3'b101, 32'd7, 32'd0);
    check("divu_dz_res", result, 32'hFFFF_FFFF);
    mdu_run(3'b100, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_res", result, 32'hFFFF_FFFD);
    mdu_run(3'b110, 32'hFFFF_FFF9, 32'd2);
    check("rem_neg_res", result, 32'hFFFF_FFFF);
    mdu_run(3'b100, 32'hFFFF_FFFB, 32'd0);
    check("div_dz_signed_res", result, 32'hFFFF_FFFF);
    mdu_run(3'b110, 32'hFFFF_FFFB, 32'd0);
    check("rem_dz_signed_res", result, 32'hFFFF_FFFB);

    // Flush mid-divide
    issue(7'b0110011, 3'b100, 7'b0000001, 4'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    flush = 1'b1;
    #1;
    checkb("flush_blocks_ready", in_ready, 1'b0);
    tick;
    flush = 1'b0;
    #1;
    checkb("flush_in_ready", in_ready, 1'b1);
    checkb("flush_busy", busy, 1'b0);
    seen_ov = 1'b0;
    repeat (40) begin
      tick;
      if (out_valid) seen_ov = 1'b1;
    end
    checkb("flush_no_ov", seen_ov, 1'b0);

    // flush together with in_valid: not accepted
    issue(7'b0010011, 3'd0, 7'd0, 4'd0, 1'b0, 1'b1, 32'd1, 32'd0, 32'd1, 32'd0);
    flush = 1'b1;
    #1;
    checkb("flush_iv_ready", in_ready, 1'b0);
    tick;
    checkb("flush_iv_no_ov", out_valid, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick;

    // Asynchronous reset mid-divide
    issue(7'b0110011, 3'b100, 7'b0000001, 4'd0, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    #2;
    rst = 1'b1;
    #1;
    checkb("arst_busy", busy, 1'b0);
    checkb("arst_in_ready", in_ready, 1'b1);
    checkb("arst_out_valid", out_valid, 1'b0);
    check("arst_result", result, 32'h0);
    check("arst_target", target, 32'h0);
    tick;
    rst = 1'b0;
    issue(7'b0110011, 3'd0, 7'd0, 4'd2, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
    tick;
    checkb("post_rst_ov", out_valid, 1'b1);
    check("post_rst_xor", result, 32'hFF00);
    in_valid = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
